// File: rtl/mm_result_collector.sv
// Result collector for the matrix-multiply engine: buffers one streamed result job,
// recovers its row/column shape, then replays it to the host over ready/valid.
module mm_result_collector #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 16,
    parameter int DIM_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mm_busy,
    input  logic                     mm_is_legal,
    input  logic                     mm_valid,
    input  logic signed [DATA_W-1:0] mm_data,
    input  logic                     mm_change_row,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_last,
    output logic [DIM_W-1:0]         res_rows,
    output logic [DIM_W-1:0]         res_cols,
    output logic                     illegal,
    output logic                     shape_err,
    output logic                     overflow,
    output logic                     job_lost
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(4);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
    state_t state, state_nxt;

    logic                     busy_d;
    logic                     start, job_end, take, wr_ok, xfer, part_row;
    logic [PTR_W-1:0]         wr_ptr, rd_ptr, rd_nxt, wr_last;
    logic [DIM_W-1:0]         col_cnt, row_cnt, cols, rows_fin, cols_fin;
    logic signed [DATA_W-1:0] mem [DEPTH];

    // Row/column counts saturate at the largest supported dimension.
    function automatic logic [DIM_W-1:0] dim_inc(input logic [DIM_W-1:0] v);
        return (v >= DIM_MAX) ? DIM_MAX : v + 1'b1;
    endfunction

    assign start    = mm_busy & ~busy_d;
    assign job_end  = ~mm_busy & busy_d;
    assign take     = (state == COLLECT) && mm_valid && !job_end;
    assign wr_ok    = take && (wr_ptr < PTR_MAX);
    assign xfer     = (state == DRAIN) && rd_valid && rd_ready;
    assign rd_nxt   = rd_ptr + 1'b1;
    assign wr_last  = wr_ptr - 1'b1;
    // A trailing row without change_row still counts as a row.
    assign part_row = (col_cnt != '0);
    assign rows_fin = part_row ? dim_inc(row_cnt) : row_cnt;
    assign cols_fin = (row_cnt == '0) ? col_cnt : cols;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && mm_is_legal) state_nxt = COLLECT;
            COLLECT: if (job_end) state_nxt = (wr_ptr == '0) ? IDLE : DRAIN;
            DRAIN:   if (xfer && rd_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer write stage
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= mm_data;
    end

    // Control and replay stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_d    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            cols      <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            res_rows  <= '0;
            res_cols  <= '0;
            illegal   <= 1'b0;
            shape_err <= 1'b0;
            overflow  <= 1'b0;
            job_lost  <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy_d   <= mm_busy;
            illegal  <= (state == IDLE) && start && !mm_is_legal;
            job_lost <= (state != IDLE) && start;
            case (state)
                IDLE: begin
                    if (start && mm_is_legal) begin
                        wr_ptr    <= '0;
                        col_cnt   <= '0;
                        row_cnt   <= '0;
                        cols      <= '0;
                        shape_err <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (take) begin
                        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                        else       overflow <= 1'b1;
                        if (mm_change_row) begin
                            row_cnt <= dim_inc(row_cnt);
                            col_cnt <= '0;
                            if (row_cnt == '0)                   cols      <= dim_inc(col_cnt);
                            else if (dim_inc(col_cnt) != cols) shape_err <= 1'b1;
                        end else begin
                            col_cnt <= dim_inc(col_cnt);
                        end
                    end
                    if (job_end) begin
                        if (wr_ptr == '0) begin
                            res_rows <= '0;
                            res_cols <= '0;
                        end else begin
                            res_rows <= rows_fin;
                            res_cols <= cols_fin;
                            rd_valid <= 1'b1;
                            rd_ptr   <= '0;
                            rd_data  <= mem[0];
                            rd_last  <= (wr_ptr == PTR_W'(1));
                            if (part_row && row_cnt != '0 && col_cnt != cols) shape_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (rd_last) begin
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            rd_ptr   <= '0;
                        end else begin
                            rd_ptr  <= rd_nxt;
                            rd_data <= mem[rd_nxt[AW-1:0]];
                            rd_last <= (rd_nxt == wr_last);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector: shape recovery, replay order, backpressure,
// fault flags and collision/reset behaviour.
module tb_mm_result_collector;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mm_busy = 1'b0;
    logic               mm_is_legal = 1'b0;
    logic               mm_valid = 1'b0;
    logic signed [19:0] mm_data = '0;
    logic               mm_change_row = 1'b0;
    logic               rd_ready = 1'b0;
    logic               rd_valid;
    logic signed [19:0] rd_data;
    logic               rd_last;
    logic [2:0]         res_rows;
    logic [2:0]         res_cols;
    logic               illegal;
    logic               shape_err;
    logic               overflow;
    logic               job_lost;

    int errors = 0;
    int checks = 0;
    int exp_q [16];

    mm_result_collector #(.DATA_W(20), .DEPTH(16), .DIM_W(3)) dut (
        .clk(clk), .rst(rst), .mm_busy(mm_busy), .mm_is_legal(mm_is_legal),
        .mm_valid(mm_valid), .mm_data(mm_data), .mm_change_row(mm_change_row),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .res_rows(res_rows), .res_cols(res_cols), .illegal(illegal),
        .shape_err(shape_err), .overflow(overflow), .job_lost(job_lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic legal);
        mm_busy = 1'b1;
        mm_is_legal = legal;
        tick();
        mm_is_legal = 1'b0;
    endtask

    task automatic send(input int d, input logic cr);
        mm_valid = 1'b1;
        mm_data = 20'(d);
        mm_change_row = cr;
        tick();
        mm_valid = 1'b0;
        mm_change_row = 1'b0;
    endtask

    task automatic end_job();
        mm_busy = 1'b0;
        tick();
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 32'(rd_valid), 1);
            chk($sformatf("%s_data%0d", tag, i), 32'(rd_data), exp_q[i]);
            chk($sformatf("%s_last%0d", tag, i), 32'(rd_last), (i == n - 1) ? 1 : 0);
            rd_ready = 1'b1;
            tick();
        end
        chk($sformatf("%s_done", tag), 32'(rd_valid), 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rows", 32'(res_rows), 0);
        chk("rst_flags", {28'd0, illegal, shape_err, overflow, job_lost}, 0);
        rst = 1'b0;
        tick();

        // 2x2 job, first read one cycle after end
        rd_ready = 1'b1;
        start_job(1'b1);
        send(1, 1'b0); send(2, 1'b1); send(3, 1'b0); send(4, 1'b1);
        end_job();
        chk("j1_rows", 32'(res_rows), 2);
        chk("j1_cols", 32'(res_cols), 2);
        exp_q[0] = 1; exp_q[1] = 2; exp_q[2] = 3; exp_q[3] = 4;
        drain(4, "j1");

        // illegal start with a concurrent valid
        mm_busy = 1'b1; mm_is_legal = 1'b0; mm_valid = 1'b1; mm_data = 20'd99;
        tick();
        mm_valid = 1'b0;
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_no_rd", 32'(rd_valid), 0);
        tick();
        chk("ill_pulse_end", 32'(illegal), 0);
        end_job();
        chk("ill_no_drain", 32'(rd_valid), 0);
        chk("ill_rows_kept", 32'(res_rows), 2);

        // 1x3 with trailing row lacking change_row, backpressure 1,0,0,1,1
        start_job(1'b1);
        send(-7, 1'b0); send(0, 1'b0); send(524287, 1'b0);
        end_job();
        chk("bp_rows", 32'(res_rows), 1);
        chk("bp_cols", 32'(res_cols), 3);
        chk("bp_d0", 32'(rd_data), -7);
        rd_ready = 1'b1; tick();
        chk("bp_d1", 32'(rd_data), 0);
        rd_ready = 1'b0; tick();
        chk("bp_hold1", 32'(rd_data), 0);
        chk("bp_hold1_v", 32'(rd_valid), 1);
        rd_ready = 1'b0; tick();
        chk("bp_hold2", 32'(rd_data), 0);
        chk("bp_hold2_last", 32'(rd_last), 0);
        rd_ready = 1'b1; tick();
        chk("bp_d2", 32'(rd_data), 524287);
        chk("bp_last", 32'(rd_last), 1);
        rd_ready = 1'b1; tick();
        chk("bp_done", 32'(rd_valid), 0);

        // 4x4 of the most negative value
        start_job(1'b1);
        for (int i = 0; i < 16; i++) send(-524288, (i % 4) == 3);
        end_job();
        chk("neg_rows", 32'(res_rows), 4);
        chk("neg_cols", 32'(res_cols), 4);
        chk("neg_ovf", 32'(overflow), 0);
        chk("neg_shape", 32'(shape_err), 0);
        for (int i = 0; i < 16; i++) exp_q[i] = -524288;
        drain(16, "neg");

        // 17 elements: overflow, first 16 kept
        start_job(1'b1);
        for (int i = 0; i < 17; i++) send(i, (i % 4) == 3);
        end_job();
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 0; i < 16; i++) exp_q[i] = i;
        drain(16, "ovf");

        // rows of 3 then 2, then a colliding start during drain
        rd_ready = 1'b0;
        start_job(1'b1);
        send(10, 1'b0); send(11, 1'b0); send(12, 1'b1); send(13, 1'b0); send(14, 1'b1);
        end_job();
        chk("shp_err", 32'(shape_err), 1);
        chk("shp_ovf_clr", 32'(overflow), 0);
        chk("shp_rows", 32'(res_rows), 2);
        chk("shp_cols", 32'(res_cols), 3);
        mm_busy = 1'b1;
        tick();
        chk("lost_pulse", 32'(job_lost), 1);
        chk("lost_hold_v", 32'(rd_valid), 1);
        chk("lost_hold_d", 32'(rd_data), 10);
        mm_busy = 1'b0;
        tick();
        chk("lost_pulse_end", 32'(job_lost), 0);
        for (int i = 0; i < 5; i++) exp_q[i] = 10 + i;
        drain(5, "shp");

        // reset during drain
        rd_ready = 1'b0;
        start_job(1'b1);
        send(5, 1'b0); send(6, 1'b1);
        end_job();
        chk("rst_pre_v", 32'(rd_valid), 1);
        rst = 1'b1;
        tick();
        chk("rstd_valid", 32'(rd_valid), 0);
        chk("rstd_rows", 32'(res_rows), 0);
        chk("rstd_data", 32'(rd_data), 0);
        rst = 1'b0;
        tick();
        start_job(1'b1);
        send(7, 1'b0);
        end_job();
        chk("post_rows", 32'(res_rows), 1);
        chk("post_cols", 32'(res_cols), 1);
        exp_q[0] = 7;
        drain(1, "post");

        // empty job goes straight back to idle
        start_job(1'b1);
        end_job();
        chk("empty_v", 32'(rd_valid), 0);
        chk("empty_rows", 32'(res_rows), 0);
        chk("empty_cols", 32'(res_cols), 0);
        tick();
        chk("empty_v2", 32'(rd_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
